// File: rtl/intadd_pkg.sv
// Shared definitions for the intadd issue stage: precision codes, micro-instruction
// field positions, FSM state encoding and the micro-instruction pack helper.
package intadd_pkg;

   localparam logic [1:0] PREC_8  = 2'b00;
   localparam logic [1:0] PREC_32 = 2'b11;

   localparam int unsigned CRU_W          = 11;
   localparam int unsigned CRU_INST_VALID = 10;
   localparam int unsigned CRU_PREC_S0_HI = 9;
   localparam int unsigned CRU_PREC_S0_LO = 8;
   localparam int unsigned CRU_PREC_S1_HI = 7;
   localparam int unsigned CRU_PREC_S1_LO = 6;
   localparam int unsigned CRU_PREC_S2_HI = 5;
   localparam int unsigned CRU_PREC_S2_LO = 4;
   localparam int unsigned CRU_SIGN_S0    = 3;
   localparam int unsigned CRU_SIGN_S1    = 2;
   localparam int unsigned CRU_SIGN_S2    = 1;
   localparam int unsigned CRU_UPDATE_ST  = 0;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } state_e;

   function automatic logic prec_legal(input logic [1:0] prec);
      return (prec == PREC_8) || (prec == PREC_32);
   endfunction

   // sign = {sign_s0, sign_s1, sign_s2}; 32-bit mode has no third signed operand.
   function automatic logic [CRU_W-1:0] cru_pack(input logic [1:0] prec,
                                                 input logic [2:0] sign,
                                                 input logic       update_st);
      logic [CRU_W-1:0] cru;
      cru                                 = '0;
      cru[CRU_INST_VALID]                 = 1'b1;
      cru[CRU_PREC_S0_HI:CRU_PREC_S0_LO]  = prec;
      cru[CRU_PREC_S1_HI:CRU_PREC_S1_LO]  = prec;
      cru[CRU_PREC_S2_HI:CRU_PREC_S2_LO]  = prec;
      cru[CRU_SIGN_S0]                    = sign[2];
      cru[CRU_SIGN_S1]                    = sign[1];
      cru[CRU_SIGN_S2]                    = (prec == PREC_32) ? 1'b0 : sign[0];
      cru[CRU_UPDATE_ST]                  = update_st;
      return cru;
   endfunction

endpackage

// File: rtl/intadd_issue.sv
// Single-command issue stage for the intadd unit: accepts one command, pulses a
// micro-instruction for one cycle, waits LAT cycles and holds the result until consumed.
module intadd_issue
   import intadd_pkg::*;
#(
   parameter int unsigned LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_prec,
   input  logic [2:0]       cmd_sign,
   input  logic             cmd_update_st,
   input  logic [127:0]     cmd_src0,
   input  logic [127:0]     cmd_src1,
   input  logic [127:0]     cmd_src2,
   output logic [CRU_W-1:0] cru_intadd,
   output logic [127:0]     src_reg0,
   output logic [127:0]     src_reg1,
   output logic [127:0]     src_reg2,
   input  logic [127:0]     dst_reg0,
   input  logic [127:0]     dst_reg1,
   input  logic [127:0]     st,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [127:0]     rsp_dst0,
   output logic [127:0]     rsp_dst1,
   output logic [127:0]     rsp_st,
   output logic             rsp_err,
   output logic             busy,
   output logic [15:0]      issue_cnt
);

   localparam logic [3:0] WaitLoad = 4'(LAT);

   state_e     state_q, state_d;
   logic [1:0] prec_q;
   logic [2:0] sign_q;
   logic       upd_q;
   logic [3:0] wait_cnt_q;
   logic       accept;
   logic       wait_done;

   assign accept    = cmd_valid && (state_q == StIdle);
   assign wait_done = (state_q == StWait) && (wait_cnt_q <= 4'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               state_d = prec_legal(cmd_prec) ? StIssue : StResp;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (wait_cnt_q <= 4'd1) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready  = (state_q == StIdle);
      busy       = (state_q != StIdle);
      rsp_valid  = (state_q == StResp);
      cru_intadd = '0;
      if (state_q == StIssue) begin
         cru_intadd = cru_pack(prec_q, sign_q, upd_q);
      end
   end

   // Operands go straight into the src registers so they hold the last issued values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prec_q   <= PREC_8;
         sign_q   <= '0;
         upd_q    <= 1'b0;
         src_reg0 <= '0;
         src_reg1 <= '0;
         src_reg2 <= '0;
      end else if (accept && prec_legal(cmd_prec)) begin
         prec_q   <= cmd_prec;
         sign_q   <= cmd_sign;
         upd_q    <= cmd_update_st;
         src_reg0 <= cmd_src0;
         src_reg1 <= cmd_src1;
         src_reg2 <= (cmd_prec == PREC_32) ? '0 : cmd_src2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
      end else if (state_q == StIssue) begin
         wait_cnt_q <= WaitLoad;
      end else if (state_q == StWait) begin
         wait_cnt_q <= wait_done ? 4'd0 : wait_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         issue_cnt <= '0;
      end else if (state_q == StIssue) begin
         issue_cnt <= issue_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_dst0 <= '0;
         rsp_dst1 <= '0;
         rsp_st   <= '0;
         rsp_err  <= 1'b0;
      end else if (accept && !prec_legal(cmd_prec)) begin
         rsp_dst0 <= '0;
         rsp_dst1 <= '0;
         rsp_st   <= '0;
         rsp_err  <= 1'b1;
      end else if (wait_done) begin
         rsp_dst0 <= dst_reg0;
         rsp_dst1 <= dst_reg1;
         rsp_st   <= st;
      end else if ((state_q == StResp) && rsp_ready) begin
         rsp_err  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_intadd_issue.sv
// Scoreboard bench for intadd_issue: directed commands push expected responses,
// a negedge monitor pops and compares whenever rsp_valid is presented.
module tb_intadd_issue;

   localparam int unsigned LAT  = 1;
   localparam int unsigned LAT3 = 3;

   typedef struct packed {
      logic [127:0] d0;
      logic [127:0] d1;
      logic [127:0] st;
      logic         err;
      logic [31:0]  cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         b_rst_n = 1'b0;
   logic [31:0]  cyc = '0;

   logic         cmd_valid = 1'b0;
   logic         b_cmd_valid = 1'b0;
   logic [1:0]   cmd_prec = '0;
   logic [2:0]   cmd_sign = '0;
   logic         cmd_update_st = 1'b0;
   logic [127:0] cmd_src0 = '0;
   logic [127:0] cmd_src1 = '0;
   logic [127:0] cmd_src2 = '0;
   logic         rsp_ready = 1'b1;
   logic         b_rsp_ready = 1'b1;
   logic [127:0] dst_reg0, dst_reg1, st;

   logic         cmd_ready, rsp_valid, rsp_err, busy;
   logic [10:0]  cru_intadd;
   logic [127:0] src_reg0, src_reg1, src_reg2, rsp_dst0, rsp_dst1, rsp_st;
   logic [15:0]  issue_cnt;

   logic         b_cmd_ready, b_rsp_valid, b_rsp_err, b_busy;
   logic [10:0]  b_cru_intadd;
   logic [127:0] b_src_reg0, b_src_reg1, b_src_reg2, b_rsp_dst0, b_rsp_dst1, b_rsp_st;
   logic [15:0]  b_issue_cnt;

   int           checks = 0;
   int           errors = 0;
   exp_t         exp_q[$];
   exp_t         cur;
   logic         mon_en = 1'b1;
   logic         prev_v = 1'b0;
   logic         have_cur = 1'b0;
   logic [15:0]  exp_cnt = '0;
   logic [127:0] last0 = '0, last1 = '0, last2 = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   // Stand-in intadd results change every cycle, so the capture edge is observable.
   assign dst_reg0 = {4{32'hD000_0000 | cyc}};
   assign dst_reg1 = {4{32'hE000_0000 | cyc}};
   assign st       = {4{32'h5A00_0000 | cyc}};

   intadd_issue #(.LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_prec(cmd_prec), .cmd_sign(cmd_sign), .cmd_update_st(cmd_update_st),
      .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
      .cru_intadd(cru_intadd), .src_reg0(src_reg0), .src_reg1(src_reg1), .src_reg2(src_reg2),
      .dst_reg0(dst_reg0), .dst_reg1(dst_reg1), .st(st),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_dst0(rsp_dst0), .rsp_dst1(rsp_dst1), .rsp_st(rsp_st),
      .rsp_err(rsp_err), .busy(busy), .issue_cnt(issue_cnt)
   );

   intadd_issue #(.LAT(LAT3)) u_dut3 (
      .clk(clk), .rst_n(b_rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_prec(cmd_prec), .cmd_sign(cmd_sign), .cmd_update_st(cmd_update_st),
      .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
      .cru_intadd(b_cru_intadd), .src_reg0(b_src_reg0), .src_reg1(b_src_reg1),
      .src_reg2(b_src_reg2), .dst_reg0(dst_reg0), .dst_reg1(dst_reg1), .st(st),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_dst0(b_rsp_dst0), .rsp_dst1(b_rsp_dst1), .rsp_st(b_rsp_st),
      .rsp_err(b_rsp_err), .busy(b_busy), .issue_cnt(b_issue_cnt)
   );

   function automatic logic [127:0] rep(input logic [31:0] w);
      return {4{w}};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops on each rising rsp_valid, then checks the held response every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n || !mon_en) begin
            prev_v   = 1'b0;
            have_cur = 1'b0;
         end else begin
            if (rsp_valid && !prev_v) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  have_cur = 1'b0;
                  $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required 0", cyc);
               end else begin
                  cur      = exp_q.pop_front();
                  have_cur = 1'b1;
                  chk("rsp_timing", 128'(cyc), 128'(cur.cyc));
               end
            end
            if (rsp_valid && have_cur) begin
               chk("rsp_dst0", rsp_dst0, cur.d0);
               chk("rsp_dst1", rsp_dst1, cur.d1);
               chk("rsp_st", rsp_st, cur.st);
               chk("rsp_err", 128'(rsp_err), 128'(cur.err));
            end
            prev_v = rsp_valid;
         end
      end
   end

   task automatic send(input logic [1:0] prec, input logic [2:0] sign, input logic upd,
                       input logic [127:0] s0, input logic [127:0] s1, input logic [127:0] s2,
                       input logic [10:0] exp_cru);
      exp_t        e;
      logic        legal;
      logic [31:0] acc;
      legal = (prec == 2'b00) || (prec == 2'b11);
      @(negedge clk);
      chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
      cmd_prec      = prec;
      cmd_sign      = sign;
      cmd_update_st = upd;
      cmd_src0      = s0;
      cmd_src1      = s1;
      cmd_src2      = s2;
      cmd_valid     = 1'b1;
      acc           = cyc;
      if (legal) begin
         e.d0  = rep(32'hD000_0000 | (acc + 32'(LAT) + 32'd1));
         e.d1  = rep(32'hE000_0000 | (acc + 32'(LAT) + 32'd1));
         e.st  = rep(32'h5A00_0000 | (acc + 32'(LAT) + 32'd1));
         e.err = 1'b0;
         e.cyc = acc + 32'(LAT) + 32'd2;
      end else begin
         e.d0  = '0;
         e.d1  = '0;
         e.st  = '0;
         e.err = 1'b1;
         e.cyc = acc + 32'd1;
      end
      exp_q.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("cru_issue", 128'(cru_intadd), legal ? 128'(exp_cru) : 128'(0));
      if (legal) begin
         last0   = s0;
         last1   = s1;
         last2   = (prec == 2'b11) ? '0 : s2;
         exp_cnt = exp_cnt + 16'd1;
         chk("src_reg0", src_reg0, last0);
         chk("src_reg1", src_reg1, last1);
         chk("src_reg2", src_reg2, last2);
      end
      @(negedge clk);
      chk("cru_after_issue", 128'(cru_intadd), 128'(0));
      chk("src_hold0", src_reg0, last0);
      chk("src_hold2", src_reg2, last2);
      if (!legal && rsp_ready) chk("err_cleared", 128'(rsp_err), 128'(0));
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(name, 128'(busy), 128'(0));
      chk("issue_cnt", 128'(issue_cnt), 128'(exp_cnt));
   endtask

   task automatic wait_rsp(input string name);
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, 128'(rsp_valid), 128'(1));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: still running at time %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      int          n_issue;
      int          guard;
      logic        seen;
      logic [31:0] acc;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_rsp_err", 128'(rsp_err), 128'(0));
      chk("rst_cru", 128'(cru_intadd), 128'(0));
      chk("rst_src0", src_reg0, '0);
      chk("rst_src2", src_reg2, '0);
      chk("rst_rsp_dst0", rsp_dst0, '0);
      chk("rst_rsp_st", rsp_st, '0);
      chk("rst_issue_cnt", 128'(issue_cnt), 128'(0));
      rst_n   = 1'b1;
      b_rst_n = 1'b1;

      // 32-bit mode: third operand and its sign suppressed
      send(2'b11, 3'b110, 1'b1, {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, {4{32'hCAFE_F00D}},
           11'h7FD);
      wait_idle("idle_32a");
      send(2'b00, 3'b101, 1'b1, {4{32'h1234_5678}}, {4{32'h0F0F_0F0F}}, {4{32'hA5A5_5A5A}},
           11'h40B);
      wait_idle("idle_8a");
      send(2'b01, 3'b111, 1'b1, {4{32'hDEAD_BEEF}}, {4{32'h1111_1111}}, {4{32'h2222_2222}},
           11'h000);
      wait_idle("idle_ill01");
      send(2'b00, 3'b000, 1'b0, {4{32'h8000_0000}}, {4{32'hFFFF_FFFF}}, {4{32'h0000_00FF}},
           11'h400);
      wait_idle("idle_8b");
      send(2'b10, 3'b000, 1'b0, {4{32'h3333_3333}}, {4{32'h4444_4444}}, {4{32'h5555_5555}},
           11'h000);
      wait_idle("idle_ill10");
      send(2'b11, 3'b011, 1'b1, {4{32'h0000_FFFF}}, {4{32'hFFFF_0000}}, {4{32'h7777_7777}},
           11'h7F5);
      wait_idle("idle_32b");

      // Back-pressure: response held, new commands ignored
      rsp_ready = 1'b0;
      send(2'b00, 3'b010, 1'b0, {4{32'h0102_0304}}, {4{32'h0506_0708}}, {4{32'h090A_0B0C}},
           11'h404);
      wait_rsp("hold_rsp_valid");
      for (int i = 0; i < 5; i++) begin
         cmd_prec  = 2'b00;
         cmd_valid = 1'b1;
         @(negedge clk);
         chk("hold_cmd_ready", 128'(cmd_ready), 128'(0));
         chk("hold_cru", 128'(cru_intadd), 128'(0));
         chk("hold_valid", 128'(rsp_valid), 128'(1));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("release_busy", 128'(busy), 128'(0));
      chk("release_cmd_ready", 128'(cmd_ready), 128'(1));
      chk("release_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("release_issue_cnt", 128'(issue_cnt), 128'(exp_cnt));

      // Reset while a response is held
      rsp_ready = 1'b0;
      send(2'b11, 3'b111, 1'b1, {4{32'h6666_6666}}, {4{32'h9999_9999}}, {4{32'hBBBB_BBBB}},
           11'h7FD);
      wait_rsp("pre_rst_valid");
      rst_n = 1'b0;
      @(negedge clk);
      exp_q.delete();
      exp_cnt = '0;
      last0   = '0;
      last1   = '0;
      last2   = '0;
      chk("rresp_valid", 128'(rsp_valid), 128'(0));
      chk("rresp_dst0", rsp_dst0, '0);
      chk("rresp_dst1", rsp_dst1, '0);
      chk("rresp_err", 128'(rsp_err), 128'(0));
      chk("rresp_busy", 128'(busy), 128'(0));
      chk("rresp_issue_cnt", 128'(issue_cnt), 128'(0));
      chk("rresp_src1", src_reg1, '0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;

      // LAT=3 instance: latency and capture edge
      @(negedge clk);
      cmd_prec      = 2'b00;
      cmd_sign      = 3'b101;
      cmd_update_st = 1'b1;
      cmd_src0      = {4{32'hABCD_0001}};
      b_cmd_valid   = 1'b1;
      acc           = cyc;
      @(negedge clk);
      b_cmd_valid = 1'b0;
      chk("b_cru_issue", 128'(b_cru_intadd), 128'(11'h40B));
      n = 1;
      while (b_rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b_rsp_latency", 128'(n), 128'(LAT3 + 2));
      chk("b_rsp_dst0", b_rsp_dst0, rep(32'hD000_0000 | (acc + 32'(LAT3) + 32'd1)));
      chk("b_rsp_st", b_rsp_st, rep(32'h5A00_0000 | (acc + 32'(LAT3) + 32'd1)));
      @(negedge clk);
      chk("b_idle", 128'(b_busy), 128'(0));
      chk("b_issue_cnt", 128'(b_issue_cnt), 128'(1));

      // LAT=3 instance: reset during WAIT discards the result
      b_rsp_ready = 1'b0;
      @(negedge clk);
      b_cmd_valid = 1'b1;
      @(negedge clk);
      b_cmd_valid = 1'b0;
      @(negedge clk);
      chk("b_in_wait", 128'(b_busy), 128'(1));
      b_rst_n = 1'b0;
      @(negedge clk);
      b_rst_n = 1'b1;
      chk("b_rst_busy", 128'(b_busy), 128'(0));
      chk("b_rst_cmd_ready", 128'(b_cmd_ready), 128'(1));
      chk("b_rst_cru", 128'(b_cru_intadd), 128'(0));
      chk("b_rst_issue_cnt", 128'(b_issue_cnt), 128'(0));
      chk("b_rst_src0", b_src_reg0, '0);
      chk("b_rst_src1", b_src_reg1, '0);
      chk("b_rst_src2", b_src_reg2, '0);
      chk("b_rst_dst0", b_rsp_dst0, '0);
      chk("b_rst_dst1", b_rsp_dst1, '0);
      chk("b_rst_err", 128'(b_rsp_err), 128'(0));
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (b_rsp_valid) seen = 1'b1;
      end
      chk("b_no_late_rsp", 128'(seen), 128'(0));
      chk("b_no_late_dst0", b_rsp_dst0, '0);

      chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

      // Issue counter wraps after 65536 legal issues from reset
      mon_en = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("wrap_start", 128'(issue_cnt), 128'(0));
      cmd_prec      = 2'b00;
      cmd_sign      = 3'b000;
      cmd_update_st = 1'b0;
      rsp_ready     = 1'b1;
      cmd_valid     = 1'b1;
      n_issue       = 0;
      guard         = 0;
      while (n_issue < 65536 && guard < 400000) begin
         @(negedge clk);
         guard++;
         if (cru_intadd[10]) begin
            n_issue++;
            if (n_issue == 65536) begin
               cmd_valid = 1'b0;
            end else if (n_issue == 65535) begin
               @(negedge clk);
               chk("wrap_ffff", 128'(issue_cnt), 128'(16'hFFFF));
            end
         end
      end
      cmd_valid = 1'b0;
      chk("wrap_issues", 128'(n_issue), 128'(65536));
      exp_cnt = '0;
      wait_idle("wrap_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
